// File: rtl/max7000_config_loader.sv
// Serial configuration front-end for the MAX7000 device model.
// Hunts for a sync word, shifts BIT_COUNT payload bits MSB-first into a
// shadow register, checks a trailing even-parity bit and commits the
// shadow register to the parallel bitstream bus on a pass.
module max7000_config_loader #(
  parameter int unsigned           BIT_COUNT    = 15033,
  parameter int unsigned           SYNC_WIDTH   = 16,
  parameter logic [SYNC_WIDTH-1:0] SYNC_WORD    = 16'hA5C3,
  parameter int unsigned           SYNC_TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 sdata,
  input  logic                 svalid,
  output logic                 sready,
  output logic                 busy,
  output logic                 config_done,
  output logic                 config_error,
  output logic [BIT_COUNT-1:0] bitstream
);

  localparam int unsigned CW = $clog2(BIT_COUNT + 1);
  localparam int unsigned TW = $clog2(SYNC_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    LOAD,
    CHECK,
    DONE,
    ERROR
  } state_t;

  state_t                state_q, state_d;
  logic [BIT_COUNT-1:0]  shadow_q;
  logic [CW-1:0]         cnt_q;
  logic [TW-1:0]         tmo_q;
  // The oldest sync bit is shifted out before it is ever compared, so only
  // SYNC_WIDTH-1 history bits are stored; the match uses history plus sdata.
  logic [SYNC_WIDTH-2:0] sync_q;
  logic                  par_q;

  logic                  xfer;
  logic [SYNC_WIDTH-1:0] sync_next;
  logic [TW-1:0]         tmo_next;
  logic [CW-1:0]         cnt_next;

  // Status outputs are a pure decode of the registered state.
  assign sready       = (state_q == SYNC) || (state_q == LOAD) || (state_q == CHECK);
  assign busy         = sready;
  assign config_done  = (state_q == DONE);
  assign config_error = (state_q == ERROR);

  assign xfer      = svalid && sready;
  assign sync_next = {sync_q, sdata};
  assign tmo_next  = tmo_q + TW'(1);
  assign cnt_next  = cnt_q + CW'(1);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: start wins over any simultaneous transfer.
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = SYNC;
    end else if (xfer) begin
      case (state_q)
        SYNC: begin
          if (sync_next == SYNC_WORD)              state_d = LOAD;
          else if (tmo_next == TW'(SYNC_TIMEOUT))  state_d = ERROR;
        end
        LOAD:    if (cnt_next == CW'(BIT_COUNT))   state_d = CHECK;
        CHECK:   state_d = (par_q ^ sdata) ? ERROR : DONE;
        default: ;
      endcase
    end
  end

  // Datapath: sync history, timeout/bit counters, shadow shift, parity, commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q  <= '0;
      bitstream <= '0;
      cnt_q     <= '0;
      tmo_q     <= '0;
      sync_q    <= '0;
      par_q     <= 1'b0;
    end else if (start) begin
      shadow_q <= '0;
      cnt_q    <= '0;
      tmo_q    <= '0;
      sync_q   <= '0;
      par_q    <= 1'b0;
    end else if (xfer) begin
      case (state_q)
        SYNC: begin
          sync_q <= sync_next[SYNC_WIDTH-2:0];
          tmo_q  <= tmo_next;
          par_q  <= 1'b0;
        end
        LOAD: begin
          shadow_q <= {shadow_q[BIT_COUNT-2:0], sdata};
          par_q    <= par_q ^ sdata;
          cnt_q    <= cnt_next;
        end
        CHECK: begin
          if (!(par_q ^ sdata)) bitstream <= shadow_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_max7000_config_loader.sv
// Self-checking bench for max7000_config_loader with a small payload.
// Expected results come from a stream-level reference model that searches
// the whole bit stream for the sync window and slices payload/parity out.
module tb_max7000_config_loader;

  localparam int unsigned BC  = 8;
  localparam logic [15:0] SW  = 16'hA5C3;
  localparam int unsigned TMO = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          sdata = 1'b0;
  logic          svalid = 1'b0;
  logic          sready, busy, config_done, config_error;
  logic [BC-1:0] bitstream;

  int            checks = 0;
  int            errors = 0;
  logic [BC-1:0] exp_bs = '0;
  bit            stream[$];

  max7000_config_loader #(
    .BIT_COUNT   (BC),
    .SYNC_WIDTH  (16),
    .SYNC_WORD   (SW),
    .SYNC_TIMEOUT(TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .sdata       (sdata),
    .svalid      (svalid),
    .sready      (sready),
    .busy        (busy),
    .config_done (config_done),
    .config_error(config_error),
    .bitstream   (bitstream)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic push_bits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) stream.push_back(v[i]);
  endtask

  task automatic build(input int garbage, input logic [7:0] payload, input bit flip);
    stream.delete();
    for (int i = 0; i < garbage; i++) stream.push_back(bit'($urandom_range(0, 1)));
    push_bits(SW, 16);
    push_bits({8'h00, payload}, 8);
    stream.push_back((^payload) ^ flip);
  endtask

  // Reference: first window (zero-padded history) equal to the sync word
  // within TMO bits, then 8 payload bits MSB-first and one even-parity bit.
  task automatic model(inout logic [7:0] bs, output bit ok, output int used);
    int          p;
    logic [15:0] w;
    logic [7:0]  pl;
    p = 0; ok = 1'b0; used = int'(TMO); pl = '0;
    for (int i = 1; i <= int'(TMO) && i <= stream.size(); i++) begin
      w = '0;
      for (int j = 0; j < 16; j++) if (i - 16 + j >= 0) w[15-j] = stream[i-16+j];
      if (w == SW) begin p = i; break; end
    end
    if (p != 0 && p + 8 < stream.size()) begin
      for (int k = 0; k < 8; k++) pl[7-k] = stream[p+k];
      used = p + 9;
      if (((^pl) ^ stream[p+8]) == 1'b0) begin ok = 1'b1; bs = pl; end
    end
  endtask

  task automatic do_start(input bit with_bit);
    @(negedge clk);
    start = 1'b1; svalid = with_bit; sdata = 1'b1;
    @(negedge clk);
    start = 1'b0; svalid = 1'b0;
  endtask

  // Feed the stream while the loader is busy; returns on a negedge.
  task automatic feed(input bit gap, output int xfers, output bit hung);
    int idx, cyc;
    idx = 0; cyc = 0; xfers = 0; hung = 1'b0;
    while (idx < stream.size()) begin
      if (!busy) break;
      if (cyc >= 4 * stream.size() + 20) begin hung = 1'b1; break; end
      svalid = !gap || (cyc % 2 == 1);
      sdata  = stream[idx];
      if (svalid && sready) begin idx++; xfers++; end
      cyc++;
      @(negedge clk);
    end
    svalid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({config_done, config_error, sready, busy} !== 4'b0000) begin
      errors++; $display("FAIL reset_status got=%b exp=0000", {config_done, config_error, sready, busy});
    end
    checks++;
    if (bitstream !== '0) begin
      errors++; $display("FAIL reset_bitstream got=%h exp=00", bitstream);
    end
    rst_n = 1'b1;
    exp_bs = '0;
  endtask

  task automatic test_nominal;
    int x, used; bit h, ok;
    build(0, 8'b1011_0010, 1'b0);
    do_start(1'b0);
    feed(1'b0, x, h);
    model(exp_bs, ok, used);
    checks++;
    if ({h, config_done, config_error, sready, busy} !== {1'b0, ok, !ok, 2'b00}) begin
      errors++; $display("FAIL nominal_status got=%b exp=%b", {h, config_done, config_error, sready, busy}, {1'b0, ok, !ok, 2'b00});
    end
    checks++;
    if (bitstream !== 8'hB2) begin
      errors++; $display("FAIL nominal_bitstream got=%h exp=b2", bitstream);
    end
    checks++;
    if (x !== used) begin
      errors++; $display("FAIL nominal_xfers got=%0d exp=%0d", x, used);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({config_done, sready} !== 2'b10) begin
      errors++; $display("FAIL done_hold got=%b exp=10", {config_done, sready});
    end
  endtask

  task automatic test_parity_fail;
    int x, used; bit h, ok;
    build(0, 8'b1011_0010, 1'b1);
    do_start(1'b0);
    feed(1'b0, x, h);
    model(exp_bs, ok, used);
    checks++;
    if ({h, config_done, config_error, sready, busy} !== 5'b00100) begin
      errors++; $display("FAIL parity_status got=%b exp=00100", {h, config_done, config_error, sready, busy});
    end
    checks++;
    if (bitstream !== exp_bs) begin
      errors++; $display("FAIL parity_bitstream got=%h exp=%h", bitstream, exp_bs);
    end
  endtask

  task automatic test_sync_hunt;
    int x, used; bit h, ok;
    build(5, 8'h5A, 1'b0);
    do_start(1'b0);
    feed(1'b1, x, h);
    model(exp_bs, ok, used);
    checks++;
    if ({h, config_done, config_error, bitstream} !== {3'b010, 8'h5A}) begin
      errors++; $display("FAIL hunt_result got=%b/%h exp=010/5a", {h, config_done, config_error}, bitstream);
    end
    checks++;
    if (x !== 30 || used !== 30) begin
      errors++; $display("FAIL hunt_xfers got=%0d exp=30", x);
    end
  endtask

  task automatic test_sync_timeout;
    int x, used; bit h, ok;
    stream.delete();
    for (int i = 0; i < int'(TMO); i++) stream.push_back(1'b0);
    do_start(1'b0);
    feed(1'b0, x, h);
    model(exp_bs, ok, used);
    checks++;
    if ({h, config_done, config_error, sready, busy} !== 5'b00100) begin
      errors++; $display("FAIL timeout_status got=%b exp=00100", {h, config_done, config_error, sready, busy});
    end
    checks++;
    if (x !== used) begin
      errors++; $display("FAIL timeout_xfers got=%0d exp=%0d", x, used);
    end
  endtask

  // Sync completes exactly on the last bit allowed by the timeout.
  task automatic test_sync_at_limit;
    int x, used; bit h, ok;
    stream.delete();
    for (int i = 0; i < int'(TMO) - 16; i++) stream.push_back(1'b0);
    push_bits(SW, 16);
    push_bits(16'h0069, 8);
    stream.push_back(1'b0);
    do_start(1'b0);
    feed(1'b0, x, h);
    model(exp_bs, ok, used);
    checks++;
    if ({h, config_done, config_error, bitstream} !== {3'b010, 8'h69}) begin
      errors++; $display("FAIL limit_result got=%b/%h exp=010/69", {h, config_done, config_error}, bitstream);
    end
    checks++;
    if (x !== used) begin
      errors++; $display("FAIL limit_xfers got=%0d exp=%0d", x, used);
    end
  endtask

  task automatic test_abort;
    int x, used; bit h, ok;
    stream.delete();
    push_bits(SW, 16);
    push_bits(16'h000F, 4);
    do_start(1'b0);
    feed(1'b0, x, h);
    do_start(1'b1);
    checks++;
    if ({busy, bitstream} !== {1'b1, exp_bs}) begin
      errors++; $display("FAIL abort_restart got=%b/%h exp=1/%h", busy, bitstream, exp_bs);
    end
    build(0, 8'hC3, 1'b0);
    feed(1'b0, x, h);
    model(exp_bs, ok, used);
    checks++;
    if ({h, config_done, config_error, bitstream} !== {3'b010, 8'hC3}) begin
      errors++; $display("FAIL abort_result got=%b/%h exp=010/c3", {h, config_done, config_error}, bitstream);
    end
    checks++;
    if (x !== used) begin
      errors++; $display("FAIL abort_xfers got=%0d exp=%0d", x, used);
    end
  endtask

  task automatic test_reset_mid_load;
    int x; bit h;
    stream.delete();
    push_bits(SW, 16);
    push_bits(16'h0005, 3);
    do_start(1'b0);
    feed(1'b0, x, h);
    checks++;
    if ({busy, bitstream} !== {1'b1, exp_bs}) begin
      errors++; $display("FAIL midload_pre got=%b/%h exp=1/%h", busy, bitstream, exp_bs);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({config_done, config_error, sready, busy, bitstream} !== '0) begin
      errors++; $display("FAIL async_reset got=%b/%h exp=0000/00", {config_done, config_error, sready, busy}, bitstream);
    end
    exp_bs = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random;
    int x, used; bit h, ok, gap;
    for (int n = 0; n < 12; n++) begin
      gap = bit'($urandom_range(0, 1));
      build(int'($urandom_range(0, 8)), 8'($urandom), $urandom_range(0, 3) == 0);
      do_start(bit'($urandom_range(0, 1)));
      feed(gap, x, h);
      model(exp_bs, ok, used);
      checks++;
      if ({h, config_done, config_error, sready, busy} !== {1'b0, ok, !ok, 2'b00}) begin
        errors++; $display("FAIL rand%0d_status got=%b exp=%b", n, {h, config_done, config_error, sready, busy}, {1'b0, ok, !ok, 2'b00});
      end
      checks++;
      if (bitstream !== exp_bs) begin
        errors++; $display("FAIL rand%0d_bitstream got=%h exp=%h", n, bitstream, exp_bs);
      end
      checks++;
      if (x !== used) begin
        errors++; $display("FAIL rand%0d_xfers got=%0d exp=%0d", n, x, used);
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_parity_fail();
    test_sync_hunt();
    test_sync_timeout();
    test_sync_at_limit();
    test_abort();
    test_reset_mid_load();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/max7000_config_loader.md
Name: max7000_config_loader

Overview:
- Serial configuration front-end for the MAX7000 device model. Accepts a serial programming stream, hunts for a sync word, and shifts exactly BIT_COUNT payload bits into a shadow register.
- Checks a trailing even-parity bit. On a pass, commits the shadow register to the parallel `bitstream` bus that drives the device's `bitstream` input.
- It is the writer side of the configuration interface; the device model is the consumer.

Parameters:
- BIT_COUNT, 15033, payload width; equals the device's total configuration bit count.
- SYNC_WORD, 16'hA5C3, pattern that marks the start of the payload.
- SYNC_WIDTH, 16, width of SYNC_WORD.
- SYNC_TIMEOUT, 1024, maximum bits accepted while hunting for sync before declaring an error.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse that begins or restarts a load.
- sdata  input  1  serial data bit.
- svalid  input  1  sdata is valid this cycle.
- sready  output  1  loader accepts a bit this cycle; a transfer occurs when svalid&&sready.
- busy  output  1  high in SYNC, LOAD and CHECK.
- config_done  output  1  high in DONE.
- config_error  output  1  high in ERROR.
- bitstream  output  BIT_COUNT  committed configuration.

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE, bitstream=0, shadow=0, counters=0, sync shift register=0.
  - All outputs 0.
- States: IDLE, SYNC, LOAD, CHECK, DONE, ERROR.
- sready=1 only in SYNC, LOAD and CHECK. It is a registered state decode and does not depend on svalid.
- IDLE/DONE/ERROR + start -> SYNC next cycle. On entry: clear shadow, bit counter, sync register and timeout counter. bitstream keeps its last committed value.
- SYNC, each transfer:
  - sync_reg <= {sync_reg[SYNC_WIDTH-2:0], sdata}; timeout counter increments.
  - If the post-shift value equals SYNC_WORD -> LOAD, with parity accumulator=0.
  - Else, if the timeout counter reaches SYNC_TIMEOUT on this transfer -> ERROR.
  - A match on the SYNC_TIMEOUT-th bit wins over the timeout.
  - The sync register resets only on entry to SYNC, so sync may overlap bits from earlier transfers.
- LOAD, each transfer:
  - The first payload bit lands in shadow[BIT_COUNT-1]; the last lands in shadow[0] (MSB first). Implemented as a left shift.
  - Parity accumulator ^= sdata; bit counter increments.
  - Counter width is clog2(BIT_COUNT+1).
  - On the transfer that makes the count equal BIT_COUNT -> CHECK.
- CHECK, one transfer (the parity bit):
  - If parity_acc ^ sdata == 0 -> DONE, and bitstream <= shadow on the same edge.
  - Else -> ERROR, and bitstream is unchanged.
- DONE/ERROR: hold state until start.
- Stalls: cycles with svalid=0 change nothing. There are no gaps in counting.
- start while busy: aborts immediately and restarts in SYNC next cycle. start has priority over a simultaneous transfer, so that bit is discarded. bitstream is not modified.
- rst_n asserted mid-load: everything returns to reset values, including bitstream=0.
- Latency: config_done and the new bitstream are visible on the cycle after the parity-bit transfer edge, both from the same edge.
- config_done and config_error are mutually exclusive.

Test Plan:
- Nominal load, BIT_COUNT=8:
  - Stimulus: start, then 0xA5C3, payload 8'b1011_0010, parity bit 0.
  - Response: config_done=1 and bitstream=8'hB2 on the same cycle; sready=0 afterwards.
- Parity failure:
  - Stimulus: same stream with parity bit 1.
  - Response: config_error=1; bitstream stays at the prior value (0 after reset).
- Sync hunt with leading garbage:
  - Stimulus: 5 random bits, then the sync word and payload 8'h5A, parity 0; svalid toggled every other cycle.
  - Response: bitstream=8'h5A; the total transfer count is exactly 5+16+8+1.
- Sync timeout:
  - Stimulus: SYNC_TIMEOUT=32, feed 32 zeros.
  - Response: config_error asserted after the 32nd transfer; sready=0.
- Abort and reset:
  - Stimulus: start at payload bit 4, then a full valid load of 8'hC3.
  - Response: bitstream=8'hC3 with no corruption.
  - Follow-up: assert rst_n=0 mid-LOAD.
  - Response: all outputs 0 asynchronously, before the next clock edge.
